// File: rtl/sdm_pkg.sv
// -----------------------------------------------------------------------------
// sdm_pkg
//   Shared types and helpers for the sigma-delta DAC path (interpolator,
//   modulator, and the demodulator/decimator that reuses the tick generator).
//
//   Contents:
//     DW_DEFAULT      default PCM sample width
//     pcm_t           16-bit signed PCM sample
//     interp_state_t  interpolator state (WAIT_FIRST / RUN / HOLD)
//     acc_width()     width of the interpolation accumulator for a given
//                     sample width and log2 oversampling ratio
// -----------------------------------------------------------------------------
package sdm_pkg;

    localparam int DW_DEFAULT = 16;

    typedef logic signed [15:0] pcm_t;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        RUN        = 2'd1,
        HOLD       = 2'd2
    } interp_state_t;

    // The accumulator carries the sample in its upper DW bits with OSR_LOG2
    // fractional bits below. One extra bit above the sample keeps the
    // intermediate sum acc + delta representable while walking between the
    // two full-scale extremes.
    function automatic int acc_width(input int dw, input int osr_log2);
        return dw + osr_log2 + 1;
    endfunction

endpackage

// File: rtl/sdm_tick_gen.sv
// -----------------------------------------------------------------------------
// sdm_tick_gen
//   Free-running clock divider. Counts 0..CLK_DIV-1 and asserts tick for one
//   clock whenever the count sits at CLK_DIV-1, then wraps to 0. With
//   CLK_DIV = 1 tick is high every clock. Also paces decimation in the
//   demodulator.
//
//   Parameters:
//     CLK_DIV  clocks per tick, >= 1
//
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-high reset (count returns to 0)
//     tick  out  combinational one-clock pulse every CLK_DIV clocks
// -----------------------------------------------------------------------------
module sdm_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A single-bit counter is kept for CLK_DIV = 1 so the vector is never
    // zero width; it simply stays at 0 and tick is permanently high.
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("sdm_tick_gen: CLK_DIV must be at least 1");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdm_interp.sv
// -----------------------------------------------------------------------------
// sdm_interp
//   Linear-interpolating upsampler feeding an sdm_modulator. Accepts signed
//   PCM over valid/ready at the audio rate and emits OSR = 2^OSR_LOG2 samples
//   per input sample as one-clock strobes paced by a CLK_DIV divider.
//
//   Each input sample becomes the target of a segment. A segment starts at a
//   boundary tick (phase k == 0) and walks the accumulator from the previous
//   target to the new one in OSR equal steps, so the last tick of the segment
//   leaves the accumulator exactly at target << OSR_LOG2. If no sample is
//   waiting at a boundary the output holds flat and underrun pulses (except
//   before the very first sample).
//
//   Parameters:
//     DW        sample width (signed)
//     OSR_LOG2  log2 of the interpolation factor, >= 1
//     CLK_DIV   clocks per output strobe, >= 1
//
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     valid_in   in   input sample offered
//     ready_out  out  a sample can be accepted this cycle
//     din        in   signed PCM sample
//     valid_out  out  one-clock strobe, dout is new
//     dout       out  signed interpolated sample
//     underrun   out  one-clock pulse with the strobe when a boundary finds
//                     no sample pending
// -----------------------------------------------------------------------------
module sdm_interp
    import sdm_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int OSR_LOG2 = 6,
    parameter int CLK_DIV  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [DW-1:0] din,
    output logic          valid_out,
    output logic [DW-1:0] dout,
    output logic          underrun
);

    localparam int AW = acc_width(DW, OSR_LOG2);

    if (OSR_LOG2 < 1) begin : g_bad_osr
        $error("sdm_interp: OSR_LOG2 must be at least 1");
    end

    // Per-tick increment for a segment. Both operands are sign-extended by
    // one bit so the full swing between the two extremes, +/-(2^DW - 1),
    // is representable without wrap.
    function automatic logic signed [DW:0] seg_delta(
        input logic signed [DW-1:0] target,
        input logic signed [DW-1:0] seg_end
    );
        return {target[DW-1], target} - {seg_end[DW-1], seg_end};
    endfunction

    // Sign-extend a step to accumulator width.
    function automatic logic signed [AW-1:0] widen_delta(
        input logic signed [DW:0] d
    );
        return {{OSR_LOG2{d[DW]}}, d};
    endfunction

    logic tick;

    sdm_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    interp_state_t          state_q,      state_d;
    logic                   pend_valid_q, pend_valid_d;
    logic signed [DW-1:0]   pend_q,       pend_d;
    logic [OSR_LOG2-1:0]    k_q,          k_d;
    logic signed [AW-1:0]   acc_q,        acc_d;
    logic signed [DW:0]     delta_q,      delta_d;
    logic signed [DW-1:0]   dout_q,       dout_d;
    logic                   valid_out_q,  valid_out_d;
    logic                   underrun_q,   underrun_d;

    logic                   boundary;
    logic                   accept;
    logic signed [DW-1:0]   seg_end;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        k_d          = k_q;
        acc_d        = acc_q;
        delta_d      = delta_q;
        dout_d       = dout_q;
        valid_out_d  = tick;
        underrun_d   = 1'b0;

        // Floor of acc / OSR. The accumulator is kept in range by
        // construction, so the integer part always fits DW bits and the
        // guard bit above it can be dropped here.
        seg_end  = acc_q[DW+OSR_LOG2-1:OSR_LOG2];
        boundary = tick && (k_q == '0);
        accept   = valid_in && !pend_valid_q;

        if (accept) begin
            pend_d       = din;
            pend_valid_d = 1'b1;
        end

        if (tick) begin
            k_d    = k_q + 1'b1;
            dout_d = seg_end;

            if (boundary) begin
                if (pend_valid_q) begin
                    // accept is necessarily low here (ready_out is 0), so
                    // clearing the pending flag cannot collide with a load.
                    delta_d      = seg_delta(pend_q, seg_end);
                    pend_valid_d = 1'b0;
                    state_d      = RUN;
                end else begin
                    delta_d = '0;
                    if (state_q != WAIT_FIRST) begin
                        underrun_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end

            // The step chosen at a boundary already applies on that same
            // tick, so OSR additions land exactly on the new target.
            acc_d = acc_q + widen_delta(delta_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_FIRST;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            delta_q      <= '0;
            dout_q       <= '0;
            valid_out_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            delta_q      <= delta_d;
            dout_q       <= dout_d;
            valid_out_q  <= valid_out_d;
            underrun_q   <= underrun_d;
        end
    end

    assign ready_out = !pend_valid_q;
    assign valid_out = valid_out_q;
    assign dout      = dout_q;
    assign underrun  = underrun_q;

endmodule
